// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the fetch and data paths: data priority, watchdog abort.
// Define MEM_ARB_STARVE_GUARD_EN to build the fetch anti-starvation streak counter.
module mem_arbiter #(
    parameter int TIMEOUT    = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_iREN,
    input  logic [31:0] i_iaddr,
    output logic [31:0] o_iload,
    output logic        o_ihit,
    input  logic        i_dREN,
    input  logic        i_dWEN,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dstore,
    output logic [31:0] o_dload,
    output logic        o_dhit,
    output logic        o_ramREN,
    output logic        o_ramWEN,
    output logic [31:0] o_ramaddr,
    output logic [31:0] o_ramstore,
    input  logic [31:0] i_ramload,
    input  logic        i_ram_ack,
    output logic        o_ram_err
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_badTimeout
        $error("mem_arbiter: TIMEOUT must be within 2..255");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_badStarveMax
        $error("mem_arbiter: STARVE_MAX must be within 1..7");
    end

    state_t      r_state;
    logic        r_ramREN;
    logic        r_ramWEN;
    logic [31:0] r_ramaddr;
    logic [31:0] r_ramstore;
    logic [7:0]  r_wdCount;

    logic        w_dReq;
    logic        w_forceI;
    logic        w_busy;
    logic        w_expired;
    logic        w_run;
    logic        w_ihit;
    logic        w_dhit;

    assign w_dReq    = i_dREN | i_dWEN;
    assign w_busy    = (r_state != IDLE);
    assign w_expired = w_busy & (r_wdCount == TIMEOUT_LAST);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] r_streak;

    // Streak of data grants taken over a waiting fetch; a full streak hands the next grant to fetch.
    assign w_forceI = i_iREN & (r_streak == 3'(STARVE_MAX));

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (i_iREN && w_dReq && !w_forceI) begin
                r_streak <= r_streak + 3'd1;
            end else begin
                r_streak <= '0;
            end
        end
    end
`else
    assign w_forceI = 1'b0;
`endif

    // RAM strobes and operands are registered at grant so they stay frozen until ack or abort.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state    <= IDLE;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
            r_wdCount  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wdCount <= '0;
                    if (w_dReq && !w_forceI) begin
                        r_state    <= DBUSY;
                        r_ramREN   <= ~i_dWEN;
                        r_ramWEN   <= i_dWEN;
                        r_ramaddr  <= i_daddr;
                        r_ramstore <= i_dstore;
                    end else if (i_iREN) begin
                        r_state    <= IBUSY;
                        r_ramREN   <= 1'b1;
                        r_ramWEN   <= 1'b0;
                        r_ramaddr  <= i_iaddr;
                        r_ramstore <= '0;
                    end
                end
                default: begin
                    if (i_ram_ack || w_expired) begin
                        r_state    <= IDLE;
                        r_ramREN   <= 1'b0;
                        r_ramWEN   <= 1'b0;
                        r_ramaddr  <= '0;
                        r_ramstore <= '0;
                        r_wdCount  <= '0;
                    end else begin
                        r_wdCount <= r_wdCount + 8'd1;
                    end
                end
            endcase
        end
    end

    // Every output is forced low while reset is asserted, including a cycle that aborts an access.
    assign w_run  = ~i_RST;
    assign w_ihit = w_run & (r_state == IBUSY) & i_ram_ack;
    assign w_dhit = w_run & (r_state == DBUSY) & i_ram_ack;

    assign o_ihit     = w_ihit;
    assign o_dhit     = w_dhit;
    assign o_iload    = w_ihit ? i_ramload : 32'd0;
    assign o_dload    = w_dhit ? i_ramload : 32'd0;
    assign o_ram_err  = w_run & w_expired & ~i_ram_ack;
    assign o_ramREN   = w_run & r_ramREN;
    assign o_ramWEN   = w_run & r_ramWEN;
    assign o_ramaddr  = w_run ? r_ramaddr : 32'd0;
    assign o_ramstore = w_run ? r_ramstore : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle reference model plus directed literal checks.
// Grant-order expectations follow MEM_ARB_STARVE_GUARD_EN when it is defined for the build.
module tb_mem_arbiter;

    localparam int TO = 4;
    localparam int SM = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iREN = 1'b0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic        ramAck = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] ramload = '0;

    logic [31:0] iload;
    logic [31:0] dload;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic        ihit;
    logic        dhit;
    logic        ramREN;
    logic        ramWEN;
    logic        ramErr;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(TO), .STARVE_MAX(SM)) dut (
        .i_CLK(clk), .i_RST(rst),
        .i_iREN(iREN), .i_iaddr(iaddr), .o_iload(iload), .o_ihit(ihit),
        .i_dREN(dREN), .i_dWEN(dWEN), .i_daddr(daddr), .i_dstore(dstore),
        .o_dload(dload), .o_dhit(dhit),
        .o_ramREN(ramREN), .o_ramWEN(ramWEN), .o_ramaddr(ramaddr), .o_ramstore(ramstore),
        .i_ramload(ramload), .i_ram_ack(ramAck), .o_ram_err(ramErr)
    );

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Wait for the next rising edge, then drive a fresh input vector just after it.
    task automatic applyStimulus(input logic r, input logic ir, input logic dr, input logic dw,
                                 input logic ack, input logic [31:0] ia, input logic [31:0] da,
                                 input logic [31:0] ds, input logic [31:0] rl);
        @(posedge clk);
        #1;
        rst = r; iREN = ir; dREN = dr; dWEN = dw; ramAck = ack;
        iaddr = ia; daddr = da; dstore = ds; ramload = rl;
    endtask

    // Reference model: who owns the RAM, what it latched, and the cycle its access began.
    int          owner = 0;
    logic        mWrite = 1'b0;
    logic [31:0] mAddr = '0;
    logic [31:0] mStore = '0;
    int          cycleNo = 0;
    int          startCycle = 0;
    int          streak = 0;
    int          modelGrants[$];
    int          dutGrants[$];
    bit          logGrants = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                owner  = 0;
                streak = 0;
            end else if (owner == 0) begin
                if ((dREN || dWEN) && !(GUARD && iREN && streak == SM)) begin
                    owner  = 2;
                    mWrite = dWEN;
                    mAddr  = daddr;
                    mStore = dstore;
                    streak = iREN ? streak + 1 : 0;
                    modelGrants.push_back(2);
                end else if (iREN) begin
                    owner  = 1;
                    mAddr  = iaddr;
                    streak = 0;
                    modelGrants.push_back(1);
                end else begin
                    streak = 0;
                end
                startCycle = cycleNo + 1;
            end else if (ramAck || (cycleNo - startCycle) == TO - 1) begin
                owner = 0;
            end
            cycleNo++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            begin
                bit run;
                bit expErr;
                run    = !rst;
                expErr = run && owner != 0 && !ramAck && (cycleNo - startCycle) == TO - 1;
                checkOutput("cyc ramREN", ramREN, run && (owner == 1 || (owner == 2 && !mWrite)));
                checkOutput("cyc ramWEN", ramWEN, run && owner == 2 && mWrite);
                checkOutput("cyc ramaddr", ramaddr, (run && owner != 0) ? mAddr : 32'd0);
                if (owner != 1) checkOutput("cyc ramstore", ramstore, (run && owner == 2) ? mStore : 32'd0);
                checkOutput("cyc ihit", ihit, run && owner == 1 && ramAck);
                checkOutput("cyc dhit", dhit, run && owner == 2 && ramAck);
                checkOutput("cyc iload", iload, (run && owner == 1 && ramAck) ? ramload : 32'd0);
                checkOutput("cyc dload", dload, (run && owner == 2 && ramAck) ? ramload : 32'd0);
                checkOutput("cyc ram_err", ramErr, expErr);
                if (logGrants && ihit) dutGrants.push_back(1);
                if (logGrants && dhit) dutGrants.push_back(2);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global time limit expired");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int modelStart;
        int expOrder[6];

        // Reset held two cycles with both requesters active.
        rst = 1'b1; iREN = 1'b1; dREN = 1'b1; iaddr = 32'h100; daddr = 32'h300;
        @(negedge clk);
        checkOutput("reset ramREN", ramREN, 1'b0);
        checkOutput("reset ramaddr", ramaddr, 32'd0);
        applyStimulus(1, 1, 1, 0, 0, 32'h100, 32'h300, 0, 0);
        @(negedge clk);
        checkOutput("reset hits", {29'd0, ihit, dhit, ramErr}, 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 32'h100, 32'h300, 0, 0);
        @(negedge clk);
        checkOutput("post-reset idle ramREN", ramREN, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 32'h100, 32'h300, 0, 32'h11);
        @(negedge clk);
        checkOutput("post-reset ramREN", ramREN, 1'b1);
        checkOutput("post-reset ramaddr", ramaddr, 32'h300);
        checkOutput("post-reset dload", dload, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fetch against a three-cycle RAM; later iaddr changes must be ignored.
        applyStimulus(0, 1, 0, 0, 0, 32'h100, 0, 0, 0);
        for (int b = 1; b <= 2; b++) begin
            applyStimulus(0, 0, 0, 0, 0, 32'h999, 0, 0, 0);
            @(negedge clk);
            checkOutput("fetch wait ramaddr", ramaddr, 32'h100);
            checkOutput("fetch wait ihit", ihit, 1'b0);
        end
        applyStimulus(0, 0, 0, 0, 1, 32'h999, 0, 0, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("fetch ihit", ihit, 1'b1);
        checkOutput("fetch iload", iload, 32'hDEADBEEF);
        checkOutput("fetch ramaddr", ramaddr, 32'h100);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("fetch done ihit", ihit, 1'b0);

        // Simultaneous fetch and data write: write first, then fetch after the turnaround.
        applyStimulus(0, 1, 0, 1, 0, 32'h104, 32'h200, 32'h5, 0);
        applyStimulus(0, 1, 0, 0, 1, 32'h104, 32'h200, 32'h5, 0);
        @(negedge clk);
        checkOutput("contend ramWEN", ramWEN, 1'b1);
        checkOutput("contend ramREN", ramREN, 1'b0);
        checkOutput("contend ramstore", ramstore, 32'h5);
        checkOutput("contend dhit", dhit, 1'b1);
        applyStimulus(0, 1, 0, 0, 0, 32'h104, 0, 0, 0);
        @(negedge clk);
        checkOutput("contend turnaround ramWEN", ramWEN, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 32'h104, 0, 0, 32'hCAFE);
        @(negedge clk);
        checkOutput("contend fetch ramaddr", ramaddr, 32'h104);
        checkOutput("contend ihit", ihit, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Watchdog abort on the fourth busy cycle.
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h400, 0, 0);
        for (int b = 1; b <= 3; b++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 32'h400, 0, 0);
            @(negedge clk);
            checkOutput("wd early ram_err", ramErr, 1'b0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h400, 0, 0);
        @(negedge clk);
        checkOutput("wd ram_err", ramErr, 1'b1);
        checkOutput("wd dhit", dhit, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("wd idle ramREN", ramREN, 1'b0);

        // Ack on the watchdog cycle completes normally.
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h404, 0, 0);
        for (int b = 1; b <= 3; b++) applyStimulus(0, 0, 0, 0, 0, 0, 32'h404, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h404, 0, 32'h77);
        @(negedge clk);
        checkOutput("wd-ack dhit", dhit, 1'b1);
        checkOutput("wd-ack ram_err", ramErr, 1'b0);
        checkOutput("wd-ack dload", dload, 32'h77);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Continuous fetch and data reads against a zero-wait RAM.
        expOrder = GUARD ? '{2, 2, 1, 2, 2, 1} : '{2, 2, 2, 2, 2, 2};
        modelStart = modelGrants.size();
        dutGrants.delete();
        logGrants = 1'b1;
        for (int c = 0; c < 40 && dutGrants.size() < 6; c++) begin
            applyStimulus(0, 1, 1, 0, 1, 32'h600, 32'h500, 0, 32'h55);
        end
        logGrants = 1'b0;
        checkOutput("starve grant count", (dutGrants.size() >= 6), 1'b1);
        for (int k = 0; k < 6; k++) begin
            if (k < dutGrants.size()) checkOutput($sformatf("starve dut grant %0d", k), dutGrants[k], expOrder[k]);
            if (modelStart + k < modelGrants.size())
                checkOutput($sformatf("starve model grant %0d", k), modelGrants[modelStart + k], expOrder[k]);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset during the second busy cycle abandons the access.
        applyStimulus(0, 0, 1, 0, 0, 0, 32'h700, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 32'h700, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 32'h700, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h700, 0, 32'h99);
        @(negedge clk);
        checkOutput("midreset ramREN", ramREN, 1'b0);
        checkOutput("midreset dhit", dhit, 1'b0);
        checkOutput("midreset ram_err", ramErr, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the instruction-fetch path and the data-access path of the pipelined core. It grants the shared RAM port to one requester at a time and holds the RAM request stable until the RAM acknowledges. It returns per-side hit pulses (`ihit`/`dhit`) that the hazard unit consumes for stall/advance decisions. Data accesses have priority; a configurable watchdog aborts hung accesses.

## Interface
- `TIMEOUT`, 64: cycles in a busy state without `ram_ack` before abort; 2..255.
- `STARVE_MAX`, 4: consecutive data grants with `iREN` pending before a fetch grant is forced (guard build only).
- `CLK` in 1: system clock.
- `RST` in 1: reset; one clock, synchronous, active-high.
- `iREN` in 1: instruction read request.
- `iaddr` in 32: instruction address.
- `iload` out 32: instruction data; valid when `ihit`=1.
- `ihit` out 1: fetch complete.
- `dREN` in 1: data read request.
- `dWEN` in 1: data write request.
- `daddr` in 32: data address.
- `dstore` in 32: write data.
- `dload` out 32: read data; valid when `dhit`=1.
- `dhit` out 1: data access complete.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data; valid with `ram_ack`.
- `ram_ack` in 1: RAM access done; one-cycle pulse.
- `ram_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, IBUSY, DBUSY.
- IDLE arbitration (registered transition):
  - `dREN|dWEN` -> DBUSY. Latch `daddr`, `dstore`, and the kind (write if `dWEN`, read otherwise; `dWEN` wins if both set).
  - else `iREN` -> IBUSY. Latch `iaddr`.
  - else stay in IDLE.
- Busy states drive RAM only from latched registers:
  - `ramaddr`/`ramstore` = latched values.
  - IBUSY: `ramREN`=1.
  - DBUSY: `ramREN`/`ramWEN` per latched kind.
  - In IDLE all RAM strobes are 0; `ramaddr`/`ramstore` are 0.
- Requester inputs that change during a busy state are ignored until the next IDLE.
- Completion: `ihit` = IBUSY & `ram_ack`; `dhit` = DBUSY & `ram_ack` (combinational). `iload`/`dload` = `ramload` when the matching hit is set, else 0. Next state is IDLE.
- `ram_ack` in IDLE is ignored.
- Watchdog: an 8-bit counter clears on entry to a busy state and increments each busy cycle without `ack`.
  - On the cycle the count reaches `TIMEOUT`-1 with no `ack`: pulse `ram_err`, no hit, go to IDLE.
  - `ack` on that same cycle wins: normal hit, no error.
- The requester re-requests on its own. The arbiter never retries.

## Timing
- Reset (sync, in the `RST` cycle and after): state IDLE, latches 0, counters 0. All outputs 0.
- Request sampled in IDLE at edge N -> RAM strobes asserted in cycle N+1.
- Zero-wait RAM (`ack` in the first busy cycle): hit in cycle N+1, IDLE in N+2.
- Minimum per-access occupancy is 2 cycles (busy + IDLE turnaround). The IDLE cycle lets the requester drop or advance its request after the hit.
- Strobes are held continuously from grant until `ack`/abort; never deasserted mid-access.
- `RST` mid-access: the access is abandoned, no hit, strobes 0 the next cycle.
- Simultaneous I and D requests in IDLE: D granted first; I granted at the following IDLE unless a new D request is present (subject to the Configuration section).

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A 3-bit streak counter counts DBUSY grants taken while `iREN`=1.
  - It clears on any IBUSY grant, or on any IDLE cycle with `iREN`=0.
  - When the count equals `STARVE_MAX`, the next IDLE grants I even if D is pending, and the counter clears.
- Undefined: strict D priority, counter not built. Fetch can starve indefinitely under continuous data traffic.

## Test plan
- Reset: hold `RST` 2 cycles with `iREN`=`dREN`=1 -> all outputs 0; after release, `ramREN`=1 with `ramaddr`=`daddr` on the second cycle.
- Fetch, 3-cycle RAM: `iREN`=1, `iaddr`=0x100, `ack` on the 3rd busy cycle with `ramload`=0xDEADBEEF -> `ihit`=1 and `iload`=0xDEADBEEF that cycle only; `ramaddr` stable at 0x100 for all 3 cycles.
- Contention: `iREN`=`dWEN`=1 same cycle, `daddr`=0x200, `dstore`=0x5 -> `ramWEN` first, `dhit`; then IDLE, then `ramREN` at `iaddr`, `ihit`.
- Watchdog: `TIMEOUT`=4, `dREN`, never `ack` -> `ram_err` pulse on the 4th busy cycle, no `dhit`, IDLE next. Separately, `ack` on the 4th busy cycle -> `dhit`=1, `ram_err`=0.
- Starvation, guard built, `STARVE_MAX`=2: `iREN` and `dREN` held high, zero-wait `ack` -> grant order D, D, I, D, D, I. Without the macro -> D only.
- Mid-access reset: assert `RST` in the 2nd busy cycle -> strobes 0 next cycle, no hit, `ram_err`=0.
